// File: rtl/rsa.sv
// rsa: constant-time modular exponentiation C = M^E mod N using Montgomery
// multiplication with R = 2^WIDTH. Each Montgomery multiply takes four cycles
// (MUL, MRED, TRED, FIN), and the sequence always runs 2*E_BITS+3 multiplies.
module rsa #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned E_BITS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  M,
  input  logic [E_BITS-1:0] E,
  input  logic [WIDTH-1:0]  N,
  input  logic [WIDTH-1:0]  N_INV,
  input  logic [WIDTH-1:0]  R2_MOD_N,
  output logic [WIDTH-1:0]  C,
  output logic              done
);

  localparam int unsigned TW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(E_BITS + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONV_M = 3'd1,
    CONV_X = 3'd2,
    SQR    = 3'd3,
    MUL    = 3'd4,
    OUT    = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t state_r, state_nxt;
  logic [1:0] sub_r, sub_nxt;
  logic       accept_c;
  logic       mm_active_c;

  // Operands and constants captured at start
  logic [WIDTH-1:0]  m_r, n_r, ninv_r, r2_r;
  logic [E_BITS-1:0] e_r;
  logic [CW-1:0]     cnt_r;

  // Montgomery-domain values
  logic [WIDTH-1:0] mb_r, xb_r;

  // Montgomery multiply pipeline registers
  logic [TW-1:0]    t_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH:0]   u_r;

  logic [WIDTH-1:0] c_r;
  logic             done_r;

  logic [WIDTH-1:0] a_c, b_c;
  logic [TW-1:0]    qn_c;
  logic [TW:0]      sum_c;
  logic [WIDTH:0]   u_c;
  logic [WIDTH:0]   n_ext_c;
  logic [WIDTH:0]   diff_c;
  logic [WIDTH-1:0] fin_c;

  assign C    = c_r;
  assign done = done_r;

  // State and substep registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      sub_r   <= 2'd0;
    end else begin
      state_r <= state_nxt;
      sub_r   <= sub_nxt;
    end
  end

  // Next-state logic; a multiply state advances after its FIN substep
  always_comb begin
    state_nxt   = state_r;
    sub_nxt     = sub_r;
    accept_c    = 1'b0;
    mm_active_c = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_c  = 1'b1;
          state_nxt = CONV_M;
          sub_nxt   = 2'd0;
        end
      end
      CONV_M, CONV_X, SQR, MUL, OUT: begin
        mm_active_c = 1'b1;
        sub_nxt     = sub_r + 2'd1;
        if (sub_r == 2'd3) begin
          case (state_r)
            CONV_M:  state_nxt = CONV_X;
            CONV_X:  state_nxt = SQR;
            SQR:     state_nxt = MUL;
            MUL:     state_nxt = (cnt_r == CW'(1)) ? OUT : SQR;
            OUT:     state_nxt = DONE;
            default: state_nxt = IDLE;
          endcase
        end
      end
      DONE: begin
        // The first DONE cycle publishes the result; restarts follow it
        if (start && done_r) begin
          accept_c  = 1'b1;
          state_nxt = CONV_M;
          sub_nxt   = 2'd0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand selection for the current multiply
  always_comb begin
    a_c = xb_r;
    b_c = xb_r;
    case (state_r)
      CONV_M: begin a_c = m_r;       b_c = r2_r;     end
      CONV_X: begin a_c = WIDTH'(1); b_c = r2_r;     end
      MUL:    begin                  b_c = mb_r;     end
      OUT:    begin                  b_c = WIDTH'(1); end
      default: ;
    endcase
  end

  // Reduction arithmetic: t + m*N fits in TW+1 bits, the quotient in WIDTH+1
  always_comb begin
    qn_c    = TW'(q_r) * TW'(n_r);
    sum_c   = (TW + 1)'(t_r) + (TW + 1)'(qn_c);
    u_c     = (WIDTH + 1)'(sum_c >> WIDTH);
    n_ext_c = (WIDTH + 1)'(n_r);
    diff_c  = u_r - n_ext_c;
    fin_c   = (u_r >= n_ext_c) ? WIDTH'(diff_c) : WIDTH'(u_r);
  end

  // Datapath: operand capture, multiply substeps, result publication
  always_ff @(posedge clk) begin
    if (!rst) begin
      m_r    <= '0;
      e_r    <= '0;
      n_r    <= '0;
      ninv_r <= '0;
      r2_r   <= '0;
      cnt_r  <= '0;
      mb_r   <= '0;
      xb_r   <= '0;
      t_r    <= '0;
      q_r    <= '0;
      u_r    <= '0;
      c_r    <= '0;
      done_r <= 1'b0;
    end else begin
      if (accept_c) begin
        m_r    <= M;
        e_r    <= E;
        n_r    <= N;
        ninv_r <= N_INV;
        r2_r   <= R2_MOD_N;
        done_r <= 1'b0;
      end
      if (mm_active_c) begin
        case (sub_r)
          2'd0: t_r <= TW'(a_c) * TW'(b_c);
          2'd1: q_r <= t_r[WIDTH-1:0] * ninv_r;
          2'd2: u_r <= u_c;
          2'd3: begin
            case (state_r)
              CONV_M: mb_r <= fin_c;
              CONV_X: begin
                xb_r  <= fin_c;
                cnt_r <= CW'(E_BITS);
              end
              SQR:    xb_r <= fin_c;
              MUL: begin
                // Product always computed; kept only for a set exponent bit
                if (e_r[E_BITS-1]) xb_r <= fin_c;
                e_r   <= e_r << 1;
                cnt_r <= cnt_r - CW'(1);
              end
              OUT:    xb_r <= fin_c;
              default: ;
            endcase
          end
          default: ;
        endcase
      end
      if (state_r == DONE && !done_r) begin
        c_r    <= xb_r;
        done_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rsa.sv
// tb_rsa: directed and randomized checks of rsa against a plain-arithmetic
// square-and-multiply model.
module tb_rsa;

  localparam int LAT    = 525;
  localparam int BUDGET = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] m_in, e_in, n_in, ninv_in, r2_in;
  logic [63:0] c_out;
  logic        done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  rsa #(.WIDTH(64), .E_BITS(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .M        (m_in),
    .E        (e_in),
    .N        (n_in),
    .N_INV    (ninv_in),
    .R2_MOD_N (r2_in),
    .C        (c_out),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] modexp(input logic [63:0] m, input logic [63:0] e,
                                         input logic [63:0] n);
    logic [127:0] r, b, nn;
    nn = {64'd0, n};
    b  = {64'd0, m} % nn;
    r  = 128'd1 % nn;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return 64'(r);
  endfunction

  function automatic logic [63:0] calc_ninv(input logic [63:0] n);
    logic [63:0] x;
    x = n;
    for (int i = 0; i < 6; i++) x = x * (64'd2 - n * x);
    return 64'd0 - x;
  endfunction

  function automatic logic [63:0] calc_r2(input logic [63:0] n);
    logic [128:0] t;
    t = 129'd1 << 128;
    return 64'(t % {65'd0, n});
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_inputs(input logic [63:0] m, input logic [63:0] e, input logic [63:0] n,
                            input logic [63:0] ninv, input logic [63:0] r2);
    m_in = m; e_in = e; n_in = n; ninv_in = ninv; r2_in = r2;
  endtask

  task automatic launch(input logic [63:0] m, input logic [63:0] e, input logic [63:0] n,
                        input logic [63:0] ninv, input logic [63:0] r2);
    @(negedge clk);
    set_inputs(m, e, n, ninv, r2);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    check("done_cleared", 64'(done), 64'd0);
  endtask

  task automatic wait_done(input string tag, input logic [63:0] exp_c);
    while (!done && cyc < BUDGET) step();
    check({tag, "_latency"}, 64'(cyc), 64'(LAT));
    check({tag, "_c"}, c_out, exp_c);
  endtask

  task automatic run(input string tag, input logic [63:0] m, input logic [63:0] e,
                     input logic [63:0] n, input logic [63:0] ninv, input logic [63:0] r2,
                     input logic [63:0] exp_c);
    launch(m, e, n, ninv, r2);
    wait_done(tag, exp_c);
  endtask

  logic [63:0] n17_inv, prev_c, rn, rm, re;

  initial begin
    n17_inv = 64'h0F0F0F0F0F0F0F0F;
    rst = 1'b0;
    start = 1'b1;
    set_inputs(64'd3, 64'd5, 64'd17, n17_inv, 64'd1);

    // Reset held with start asserted
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_done", 64'(done), 64'd0);
    check("rst_c", c_out, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    repeat (5) step();
    check("idle_done", 64'(done), 64'd0);
    check("idle_c", c_out, 64'd0);

    // Large base, small modulus
    run("large_m", 64'h6E6861746E686174, 64'd4, 64'd11, 64'd15092790605762360413, 64'd3, 64'd9);
    check("large_m_model", c_out, modexp(64'h6E6861746E686174, 64'd4, 64'd11));

    // Basic and boundary cases with N = 17
    run("m3_e5",  64'd3,  64'd5,  64'd17, n17_inv, 64'd1, 64'd5);
    run("m3_e16", 64'd3,  64'd16, 64'd17, n17_inv, 64'd1, 64'd1);
    run("e0",     64'd3,  64'd0,  64'd17, n17_inv, 64'd1, 64'd1);
    run("m0",     64'd0,  64'd7,  64'd17, n17_inv, 64'd1, 64'd0);
    run("m34",    64'd34, 64'd3,  64'd17, n17_inv, 64'd1, 64'd0);

    // Busy start ignored, inputs disturbed mid-run, result held meanwhile
    prev_c = c_out;
    launch(64'd3, 64'd5, 64'd17, n17_inv, 64'd1);
    repeat (100) step();
    check("hold_c", c_out, prev_c);
    check("hold_done", 64'(done), 64'd0);
    @(negedge clk);
    set_inputs(64'd5, 64'd9, 64'd23, 64'd7, 64'd4);
    start = 1'b1;
    step();
    @(negedge clk);
    start = 1'b0;
    set_inputs({$urandom(), $urandom()}, {$urandom(), $urandom()}, 64'd29, 64'd1, 64'd2);
    step();
    wait_done("busy_start", 64'd5);

    // Restart from DONE, inputs toggled during run
    launch(64'd2, 64'd10, 64'd17, n17_inv, 64'd1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      set_inputs({$urandom(), $urandom()}, {$urandom(), $urandom()},
                 {$urandom(), $urandom()}, {$urandom(), $urandom()}, {$urandom(), $urandom()});
      step();
    end
    wait_done("restart", 64'd4);

    // Abort mid-operation, then a clean run
    launch(64'd7, 64'd11, 64'd17, n17_inv, 64'd1);
    repeat (260) step();
    @(negedge clk);
    rst = 1'b0;
    step();
    check("abort_done", 64'(done), 64'd0);
    check("abort_c", c_out, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step();
    check("abort_idle", 64'(done), 64'd0);
    run("after_abort", 64'd3, 64'd5, 64'd17, n17_inv, 64'd1, 64'd5);

    // Randomized operands against the reference model
    for (int k = 0; k < 8; k++) begin
      rn = {$urandom(), $urandom()} | 64'd1;
      if (rn == 64'd1) rn = 64'd3;
      if (k < 2) rn = rn & 64'h0000_0000_0000_FFFF | 64'd1;
      if (rn == 64'd1) rn = 64'd3;
      rm = {$urandom(), $urandom()};
      re = {$urandom(), $urandom()};
      if (k == 3) re = 64'd1;
      run("random", rm, re, rn, calc_ninv(rn), calc_r2(rn), modexp(rm, re, rn));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
